// File: rtl/pmod_i2s2_codec.sv
// Stereo I2S / left-justified master for the Pmod I2S2: derives MCLK/SCLK/LRCK from one
// free-running counter, serialises a held stereo pair to the DAC and captures one from the ADC.
module pmod_i2s2_codec #(
    parameter int CLK_DIV_LOG2 = 1,
    parameter int SAMPLE_WIDTH = 24,
    parameter int MODE         = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [SAMPLE_WIDTH-1:0] tx_left,
    input  logic [SAMPLE_WIDTH-1:0] tx_right,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic                    tx_underrun,
    output logic [SAMPLE_WIDTH-1:0] rx_left,
    output logic [SAMPLE_WIDTH-1:0] rx_right,
    output logic                    rx_valid,
    output logic                    lineout_mclk,
    output logic                    lineout_lrck,
    output logic                    lineout_sclk,
    output logic                    lineout_sdout,
    output logic                    linein_mclk,
    output logic                    linein_lrck,
    output logic                    linein_sclk,
    input  logic                    linein_sdin
);

    localparam int D  = CLK_DIV_LOG2;
    localparam int SW = SAMPLE_WIDTH;
    localparam int CW = D + 8;
    localparam logic [D+1:0] RISE_PAT = {1'b0, {(D + 1){1'b1}}};

    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          hold_full_q, hold_full_d;
    logic [SW-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [SW-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
    logic          sdout_q, sdout_d;
    logic [SW-1:0] shadow_l_q, shadow_l_d, shadow_r_q, shadow_r_d;
    logic [SW-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
    logic          rx_valid_q, rx_valid_d;
    logic          underrun_q, underrun_d;

    logic          frame_end, fall_ev, rise_ev, handshake, tx_bit;
    logic [SW-1:0] src_l, src_r, nxt_word;
    logic [5:0]    nxt_map, rx_map;

    // Returns {bit_present, bit_index} for slot bit period k.
    function automatic logic [5:0] slot_map(input logic [4:0] k);
        int  ki;
        int  bi;
        logic ok;
        ki = int'(k);
        if (MODE == 1) begin
            bi = SW - 1 - ki;
            ok = (ki < SW);
        end else begin
            bi = SW - ki;
            ok = (ki >= 1) && (ki <= SW);
        end
        if (!ok) bi = 0;
        return {ok, 5'(bi)};
    endfunction

    always_comb begin
        cnt_inc   = cnt_q + CW'(1);
        frame_end = enable && (&cnt_q);
        fall_ev   = enable && (&cnt_q[D+1:0]);
        rise_ev   = enable && (cnt_q[D+1:0] == RISE_PAT);
        handshake = tx_valid && !hold_full_q;

        // At the frame boundary the next bit comes from the pair being loaded, not the old one.
        if (frame_end) begin
            src_l = hold_full_q ? hold_l_q : '0;
            src_r = hold_full_q ? hold_r_q : '0;
        end else begin
            src_l = shift_l_q;
            src_r = shift_r_q;
        end
        nxt_map  = slot_map(cnt_inc[D+6:D+2]);
        nxt_word = cnt_inc[D+7] ? src_r : src_l;
        tx_bit   = 1'b0;
        for (int i = 0; i < SW; i++) begin
            if (nxt_map[5] && (nxt_map[4:0] == 5'(i))) tx_bit = nxt_word[i];
        end
        rx_map = slot_map(cnt_q[D+6:D+2]);
    end

    always_comb begin
        cnt_d       = enable ? cnt_inc : '0;
        hold_full_d = frame_end ? handshake : (hold_full_q || handshake);
        hold_l_d    = handshake ? tx_left  : hold_l_q;
        hold_r_d    = handshake ? tx_right : hold_r_q;
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        sdout_d     = sdout_q;
        shadow_l_d  = shadow_l_q;
        shadow_r_d  = shadow_r_q;
        rx_l_d      = frame_end ? shadow_l_q : rx_l_q;
        rx_r_d      = frame_end ? shadow_r_q : rx_r_q;
        rx_valid_d  = frame_end;
        underrun_d  = frame_end && !hold_full_q;

        if (!enable) begin
            shift_l_d = '0;
            shift_r_d = '0;
            sdout_d   = 1'b0;
        end else begin
            if (frame_end) begin
                shift_l_d = src_l;
                shift_r_d = src_r;
            end
            if (fall_ev) sdout_d = tx_bit;
        end

        for (int i = 0; i < SW; i++) begin
            if (rise_ev && rx_map[5] && (rx_map[4:0] == 5'(i))) begin
                if (cnt_q[D+7]) shadow_r_d[i] = linein_sdin;
                else            shadow_l_d[i] = linein_sdin;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            shift_l_q   <= '0;
            shift_r_q   <= '0;
            sdout_q     <= 1'b0;
            shadow_l_q  <= '0;
            shadow_r_q  <= '0;
            rx_l_q      <= '0;
            rx_r_q      <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            sdout_q     <= sdout_d;
            shadow_l_q  <= shadow_l_d;
            shadow_r_q  <= shadow_r_d;
            rx_l_q      <= rx_l_d;
            rx_r_q      <= rx_r_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign tx_ready      = !hold_full_q;
    assign tx_underrun   = underrun_q;
    assign rx_left       = rx_l_q;
    assign rx_right      = rx_r_q;
    assign rx_valid      = rx_valid_q;
    assign lineout_mclk  = cnt_q[D-1];
    assign lineout_sclk  = cnt_q[D+1];
    assign lineout_lrck  = cnt_q[D+7];
    assign lineout_sdout = sdout_q;
    assign linein_mclk   = cnt_q[D-1];
    assign linein_sclk   = cnt_q[D+1];
    assign linein_lrck   = cnt_q[D+7];

endmodule
